// File: rtl/bank_tx_arbiter_if.sv
// Request/ack bus between the percept ports and the tx arbiter, plus the serial line.
interface bank_tx_arbiter_if #(
    parameter int unsigned N_PORTS = 3
);
    logic [N_PORTS-1:0]   req;
    logic [8*N_PORTS-1:0] addr;
    logic [8*N_PORTS-1:0] data;
    logic [N_PORTS-1:0]   ack;
    logic                 busy;
    logic                 tx;

    // Percept side: raises requests, sees acks and the line state
    modport master (
        output req,
        output addr,
        output data,
        input  ack,
        input  busy,
        input  tx
    );

    // Arbiter side
    modport slave (
        input  req,
        input  addr,
        input  data,
        output ack,
        output busy,
        output tx
    );
endinterface

// File: rtl/bank_tx_arbiter.sv
// Round-robin arbiter that serialises each granted request as a two-byte UART frame
// (address byte, then data byte) onto a single tx line.
module bank_tx_arbiter #(
    parameter int unsigned N_PORTS = 3,
    parameter int unsigned CLK_DIV = 434
) (
    input logic               clk,
    input logic               nRst,
    bank_tx_arbiter_if.slave  bus
);
    localparam int unsigned GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned DW = $clog2(CLK_DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BITS  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic               byte_q, byte_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         hold_q, hold_d;
    logic [GW-1:0]      last_q, last_d;
    logic [N_PORTS-1:0] ack_q, ack_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;

    logic               gnt_vld;
    logic [GW-1:0]      gnt_idx;
    logic [GW:0]        cand;
    logic               div_done;

    assign div_done = (div_q == DW'(CLK_DIV - 1));

    // Round-robin search starting one past the last granted port
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            cand = {1'b0, last_q} + (GW + 1)'(k);
            if (cand >= (GW + 1)'(N_PORTS)) begin
                cand = cand - (GW + 1)'(N_PORTS);
            end
            if (!gnt_vld && bus.req[cand[GW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[GW-1:0];
            end
        end
    end

    // Frame sequencing: start bit, 8 data bits LSB first, stop bit, twice per grant
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        last_d  = last_q;
        ack_d   = '0;
        tx_d    = tx_q;
        busy_d  = busy_q;

        if (state_q != ST_IDLE) begin
            div_d = div_done ? '0 : div_q + DW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    shift_d        = bus.addr[{gnt_idx, 3'b000} +: 8];
                    hold_d         = bus.data[{gnt_idx, 3'b000} +: 8];
                    ack_d[gnt_idx] = 1'b1;
                    last_d         = gnt_idx;
                    tx_d           = 1'b0;
                    busy_d         = 1'b1;
                    byte_d         = 1'b0;
                    div_d          = '0;
                    state_d        = ST_START;
                end
            end
            ST_START: begin
                if (div_done) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = 3'd0;
                    state_d = ST_BITS;
                end
            end
            ST_BITS: begin
                if (div_done) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (div_done) begin
                    if (!byte_q) begin
                        shift_d = hold_q;
                        byte_d  = 1'b1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        byte_d  = 1'b0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; nRst is an active-high synchronous reset that aborts any frame
    always_ff @(posedge clk) begin
        if (nRst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            shift_q <= '0;
            hold_q  <= '0;
            last_q  <= GW'(N_PORTS - 1);
            ack_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_bank_tx_arbiter.sv
// Directed bench for bank_tx_arbiter: table of frames plus reset corner cases.
module tb_bank_tx_arbiter;
    localparam int unsigned NP    = 3;
    localparam int unsigned DIV   = 4;
    localparam int          FRAME = 20 * DIV;

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    bank_tx_arbiter_if #(.N_PORTS(NP)) bus ();

    bank_tx_arbiter #(
        .N_PORTS (NP),
        .CLK_DIV (DIV)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  set;
        logic [2:0]  clr;
        logic [23:0] addr;
        logic [23:0] data;
        int          exp_port;
        logic [7:0]  exp_a;
        logic [7:0]  exp_d;
        bit          mut;
    } vec_t;

    vec_t vecs [9];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard 8N1 framing of the two bytes, LSB first
    function automatic logic [19:0] uart_frame(input logic [7:0] a, input logic [7:0] d);
        logic [19:0] f;
        f[0]  = 1'b0;
        f[9]  = 1'b1;
        f[10] = 1'b0;
        f[19] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f[1 + i]  = a[i];
            f[11 + i] = d[i];
        end
        return f;
    endfunction

    // Waits for the grant, then checks every cycle of the frame and the idle cycle after it
    task automatic run_frame(input int exp_port, input logic [7:0] ea, input logic [7:0] ed,
                             input logic [2:0] clr, input bit mut);
        int          w;
        int          bad_tx;
        int          bad_busy;
        int          bad_ack;
        logic [19:0] f;
        w = 1;
        while (w <= 200) begin
            @(negedge clk);
            if (bus.ack != '0) break;
            w++;
        end
        check("grant_wait", w, 1);
        if (w > 200) return;
        check("ack_port", {29'd0, bus.ack}, 32'd1 << exp_port);
        bus.req  = bus.req & ~clr;
        f        = uart_frame(ea, ed);
        bad_tx   = 0;
        bad_busy = 0;
        bad_ack  = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1 && mut) bus.data[7:0] = 8'hFF;
            if (bus.tx !== f[c / DIV]) bad_tx++;
            if (bus.busy !== 1'b1) bad_busy++;
            if (c > 0 && bus.ack !== '0) bad_ack++;
        end
        check("tx_stream_bad_cycles", bad_tx, 0);
        check("busy_low_cycles", bad_busy, 0);
        check("extra_ack_cycles", bad_ack, 0);
        @(negedge clk);
        check("end_busy", {31'd0, bus.busy}, 0);
        check("end_tx", {31'd0, bus.tx}, 1);
        check("end_ack", {29'd0, bus.ack}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int w;

        vecs[0] = '{3'b111, 3'b000, 24'h666564, 24'h302010, 0, 8'h64, 8'h10, 1'b0};
        vecs[1] = '{3'b000, 3'b000, 24'h666564, 24'h302010, 1, 8'h65, 8'h20, 1'b0};
        vecs[2] = '{3'b000, 3'b000, 24'h666564, 24'h302010, 2, 8'h66, 8'h30, 1'b0};
        vecs[3] = '{3'b000, 3'b111, 24'h666564, 24'h302010, 0, 8'h64, 8'h10, 1'b0};
        vecs[4] = '{3'b010, 3'b010, 24'h006500, 24'h00A500, 1, 8'h65, 8'hA5, 1'b0};
        vecs[5] = '{3'b100, 3'b100, 24'h770000, 24'h880000, 2, 8'h77, 8'h88, 1'b0};
        vecs[6] = '{3'b101, 3'b001, 24'h990033, 24'hAA0044, 0, 8'h33, 8'h44, 1'b0};
        vecs[7] = '{3'b000, 3'b100, 24'h990033, 24'hAA0044, 2, 8'h99, 8'hAA, 1'b0};
        vecs[8] = '{3'b001, 3'b001, 24'h000012, 24'h000011, 0, 8'h12, 8'h11, 1'b1};

        nRst     = 1'b1;
        bus.req  = '0;
        bus.addr = '0;
        bus.data = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, bus.tx}, 1);
        check("reset_busy", {31'd0, bus.busy}, 0);
        check("reset_ack", {29'd0, bus.ack}, 0);
        nRst = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== '0) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        for (int i = 0; i < 9; i++) begin
            bus.addr = vecs[i].addr;
            bus.data = vecs[i].data;
            bus.req  = bus.req | vecs[i].set;
            run_frame(vecs[i].exp_port, vecs[i].exp_a, vecs[i].exp_d, vecs[i].clr, vecs[i].mut);
        end

        // Abort in the middle of byte 2 of a port 0 frame, then confirm port 0 priority again
        bus.addr = 24'h00005A;
        bus.data = 24'h0000C3;
        bus.req  = 3'b001;
        w = 1;
        while (w <= 200) begin
            @(negedge clk);
            if (bus.ack != '0) break;
            w++;
        end
        check("abort_grant_wait", w, 1);
        bus.req = '0;
        repeat (52) @(negedge clk);
        check("abort_busy_before", {31'd0, bus.busy}, 1);
        nRst = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'd0, bus.tx}, 1);
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_ack", {29'd0, bus.ack}, 0);
        nRst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.ack !== '0) bad++;
        end
        check("abort_no_resume", bad, 0);

        bus.addr = 24'h00BBAA;
        bus.data = 24'h00D25C;
        bus.req  = 3'b011;
        run_frame(0, 8'hAA, 8'h5C, 3'b001, 1'b0);
        run_frame(1, 8'hBB, 8'hD2, 3'b010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
